// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port front end for a shared single-port synchronous RAM.
//
// The CPU port can load or store. The IO port is read-only.
// Each access takes two cycles:
//   GRANT_x : the address (and, for CPU stores, the write data and write
//             enable) is presented to the RAM, and x_gnt pulses.
//   DATA_x  : the RAM read data comes back, x_valid pulses, and
//             x_rdata = mem_dout.
// A new arbitration can happen in the DATA cycle. This gives back-to-back
// accesses at one per two cycles.
//
// Optional feature macro: MEMARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests, grant the requester that was not
//               granted last.
//   undefined : the CPU always wins ties.
//
// Parameters: AW address width, DW data width.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request side
//   cpu_gnt, cpu_valid, cpu_rdata    CPU response side
//   io_req/addr                      IO request side (read-only)
//   io_gnt, io_valid, io_rdata       IO response side
//   mem_addr, mem_din, mem_we        RAM command (registered)
//   mem_dout                         RAM read data (one-cycle latency)
//   busy                             high while a GRANT/DATA state is active
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic [AW-1:0] io_addr,
    output logic          io_gnt,
    output logic          io_valid,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT_CPU = 3'd1,
        GRANT_IO  = 3'd2,
        DATA_CPU  = 3'd3,
        DATA_IO   = 3'd4
    } state_t;

    state_t        state;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] io_rdata_q;
    logic          pick_cpu;
    logic          pick_io;

`ifdef MEMARB_ROUND_ROBIN_EN
    // 1 = the last grant went to IO, 0 = it went to the CPU
    logic          last_grant_io;
`endif

    // Winner selection among the current requests (used only in arbitrating states)
    always_comb begin
        pick_cpu = 1'b0;
        pick_io  = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
        if (cpu_req && io_req) begin
            pick_cpu = last_grant_io;
            pick_io  = !last_grant_io;
        end else begin
            pick_cpu = cpu_req;
            pick_io  = io_req;
        end
`else
        pick_cpu = cpu_req;
        pick_io  = io_req && !cpu_req;
`endif
    end

    // Arbiter FSM with registered grant/valid/RAM-command/busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cpu_gnt     <= 1'b0;
            io_gnt      <= 1'b0;
            cpu_valid   <= 1'b0;
            io_valid    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            busy        <= 1'b0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_grant_io <= 1'b1;
`endif
        end else begin
            // Pulses are one cycle long unless the case below sets them again
            cpu_gnt   <= 1'b0;
            io_gnt    <= 1'b0;
            cpu_valid <= 1'b0;
            io_valid  <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE, DATA_CPU, DATA_IO: begin
                    // Keep the returned data so rdata holds after the DATA cycle
                    if (state == DATA_CPU) begin
                        cpu_rdata_q <= mem_dout;
                    end
                    if (state == DATA_IO) begin
                        io_rdata_q <= mem_dout;
                    end
                    // mem_addr/mem_din/mem_we act as the latch for the winner's request
                    if (pick_cpu) begin
                        state    <= GRANT_CPU;
                        cpu_gnt  <= 1'b1;
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                        mem_we   <= cpu_we;
                        busy     <= 1'b1;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last_grant_io <= 1'b0;
`endif
                    end else if (pick_io) begin
                        state    <= GRANT_IO;
                        io_gnt   <= 1'b1;
                        mem_addr <= io_addr;
                        busy     <= 1'b1;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last_grant_io <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GRANT_CPU: begin
                    state     <= DATA_CPU;
                    cpu_valid <= 1'b1;
                    busy      <= 1'b1;
                end
                GRANT_IO: begin
                    state    <= DATA_IO;
                    io_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The RAM returns data during the DATA cycle itself, so rdata passes
    // mem_dout straight through there. At all other times it shows the
    // captured copy.
    assign cpu_rdata = (state == DATA_CPU) ? mem_dout : cpu_rdata_q;
    assign io_rdata  = (state == DATA_IO)  ? mem_dout : io_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req;
    logic [15:0] cpu_addr, cpu_wdata, io_addr;
    logic        cpu_gnt, cpu_valid, io_gnt, io_valid, mem_we, busy;
    logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_din;
    logic [15:0] mem_dout = 16'h0000;
    logic [15:0] ram [0:65535];

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_addr(io_addr),
        .io_gnt(io_gnt), .io_valid(io_valid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".cpu_gnt"},   {15'd0, cpu_gnt},   16'd0);
        check({tag, ".io_gnt"},    {15'd0, io_gnt},    16'd0);
        check({tag, ".cpu_valid"}, {15'd0, cpu_valid}, 16'd0);
        check({tag, ".io_valid"},  {15'd0, io_valid},  16'd0);
        check({tag, ".mem_we"},    {15'd0, mem_we},    16'd0);
        check({tag, ".busy"},      {15'd0, busy},      16'd0);
        check({tag, ".mem_addr"},  mem_addr,  16'd0);
        check({tag, ".mem_din"},   mem_din,   16'd0);
        check({tag, ".cpu_rdata"}, cpu_rdata, 16'd0);
        check({tag, ".io_rdata"},  io_rdata,  16'd0);
    endtask

    initial begin
        logic exp_cpu, exp_io;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[16'h0010] = 16'hBEEF;
        ram[16'h00FF] = 16'hA5A5;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; io_req = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 16'h0000; io_addr = 16'h0000;
        tick(); tick();
        check_idle_zero("reset");

        // CPU load from 0x0010
        reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h7777;
        tick();
        check("ld.cpu_gnt",  {15'd0, cpu_gnt}, 16'd1);
        check("ld.busy",     {15'd0, busy},    16'd1);
        check("ld.mem_addr", mem_addr, 16'h0010);
        check("ld.mem_we",   {15'd0, mem_we},  16'd0);
        check("ld.io_gnt",   {15'd0, io_gnt},  16'd0);
        cpu_req = 1'b0;
        tick();
        check("ld.cpu_valid", {15'd0, cpu_valid}, 16'd1);
        check("ld.cpu_rdata", cpu_rdata, 16'hBEEF);
        check("ld.gnt_off",   {15'd0, cpu_gnt}, 16'd0);
        check("ld.mem_we2",   {15'd0, mem_we},  16'd0);
        tick();
        check("ld.idle_valid", {15'd0, cpu_valid}, 16'd0);
        check("ld.idle_busy",  {15'd0, busy},      16'd0);
        check("ld.hold_rdata", cpu_rdata, 16'hBEEF);
        check("ld.hold_addr",  mem_addr,  16'h0010);

        // CPU store 0x1234 to 0x0020
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        tick();
        check("st.mem_we",   {15'd0, mem_we}, 16'd1);
        check("st.mem_addr", mem_addr, 16'h0020);
        check("st.mem_din",  mem_din,  16'h1234);
        check("st.cpu_gnt",  {15'd0, cpu_gnt}, 16'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("st.mem_we_off", {15'd0, mem_we},    16'd0);
        check("st.cpu_valid",  {15'd0, cpu_valid}, 16'd1);
        tick();
        check("st.idle_we", {15'd0, mem_we}, 16'd0);

        // Load back 0x0020
        cpu_req = 1'b1; cpu_addr = 16'h0020;
        tick();
        check("ldb.cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
        cpu_req = 1'b0;
        tick();
        check("ldb.cpu_valid", {15'd0, cpu_valid}, 16'd1);
        check("ldb.cpu_rdata", cpu_rdata, 16'h1234);
        tick();

        // IO read from 0x00FF
        io_req = 1'b1; io_addr = 16'h00FF; cpu_wdata = 16'h9999;
        tick();
        check("io.io_gnt",   {15'd0, io_gnt},  16'd1);
        check("io.cpu_gnt",  {15'd0, cpu_gnt}, 16'd0);
        check("io.mem_addr", mem_addr, 16'h00FF);
        check("io.mem_we",   {15'd0, mem_we},  16'd0);
        check("io.mem_din",  mem_din,  16'h1234);
        io_req = 1'b0;
        tick();
        check("io.io_valid",  {15'd0, io_valid},  16'd1);
        check("io.io_rdata",  io_rdata, 16'hA5A5);
        check("io.cpu_valid", {15'd0, cpu_valid}, 16'd0);
        check("io.mem_we2",   {15'd0, mem_we},    16'd0);
        tick();
        check("io.hold_rdata", io_rdata, 16'hA5A5);
        check("io.idle_valid", {15'd0, io_valid}, 16'd0);

        // Contention: both requesters held high for 8 cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        io_req = 1'b1; io_addr = 16'h00FF;
        for (int c = 1; c <= 8; c++) begin
            tick();
`ifdef MEMARB_ROUND_ROBIN_EN
            exp_cpu = (c == 1) || (c == 5);
            exp_io  = (c == 3) || (c == 7);
`else
            exp_cpu = (c % 2) == 1;
            exp_io  = 1'b0;
`endif
            check($sformatf("arb.c%0d.cpu_gnt", c), {15'd0, cpu_gnt}, {15'd0, exp_cpu});
            check($sformatf("arb.c%0d.io_gnt", c),  {15'd0, io_gnt},  {15'd0, exp_io});
        end
        cpu_req = 1'b0; io_req = 1'b0;
        tick();
        check("arb.idle_busy", {15'd0, busy}, 16'd0);
        check("arb.idle_gnt",  {15'd0, cpu_gnt | io_gnt}, 16'd0);

        // Reset asserted during GRANT_CPU of a store
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        tick();
        check("rst.mem_we_pre", {15'd0, mem_we}, 16'd1);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check_idle_zero("rst.abort");
        reset = 1'b0;
        tick();
        check_idle_zero("rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
